// File: rtl/match_controller.sv
// rtl/match_controller.sv - match FSM, per-player scores and frame tick generator for pong
module match_controller #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 3,
  parameter int FRAME_DIV    = 200000,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int PID_W        = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           pause_i,
  input  logic                           point_valid_i,
  input  logic [PID_W-1:0]               point_player_i,
  output logic                           frame_tick_o,
  output logic                           ball_run_o,
  output logic                           ball_reset_o,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
  output logic [PID_W-1:0]               winner_o,
  output logic                           winner_valid_o,
  output logic [2:0]                     state_o
);

  localparam int CNT_W  = $clog2(FRAME_DIV + 1);
  localparam int CD_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CD_W   = $clog2(CD_MAX + 1);
  localparam int SC_W   = NUM_PLAYERS * SCORE_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    PAUSE    = 3'd4,
    GAMEOVER = 3'd5
  } state_e;

  state_e             state_q, state_d, saved_q, saved_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic [SC_W-1:0]    scores_q, scores_d;
  logic [PID_W-1:0]   winner_q, winner_d;
  logic               winner_valid_q, ball_run_q, ball_reset_q;
  logic               point_ok;
  logic [SCORE_W-1:0] cur_score, new_score;

  assign cnt_d    = (cnt_q == CNT_W'(FRAME_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
  assign point_ok = point_valid_i && (32'(point_player_i) < NUM_PLAYERS);

  always_comb begin
    cur_score = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (point_player_i == PID_W'(p)) cur_score = scores_q[p*SCORE_W +: SCORE_W];
    end
    new_score = cur_score + SCORE_W'(1);
  end

  // Priority within a cycle: start > point > pause > countdown expiry.
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    cd_d     = cd_q;
    scores_d = scores_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SERVE;
          cd_d     = CD_W'(SERVE_FRAMES - 1);
          scores_d = '0;
        end
      end
      SERVE, POINT: begin
        if (start_i) begin
          state_d = IDLE;
        end else if (pause_i) begin
          saved_d = state_q;
          state_d = PAUSE;
        end else if (tick_q) begin
          if (cd_q == '0) begin
            if (state_q == SERVE) begin
              state_d = PLAY;
            end else begin
              state_d = SERVE;
              cd_d    = CD_W'(SERVE_FRAMES - 1);
            end
          end else begin
            cd_d = cd_q - CD_W'(1);
          end
        end
      end
      PLAY: begin
        if (start_i) begin
          state_d = IDLE;
        end else if (point_ok) begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (point_player_i == PID_W'(p)) scores_d[p*SCORE_W +: SCORE_W] = new_score;
          end
          if (new_score == SCORE_W'(WIN_SCORE)) begin
            state_d  = GAMEOVER;
            winner_d = point_player_i;
          end else begin
            state_d = POINT;
            cd_d    = CD_W'(POINT_FRAMES - 1);
          end
        end else if (pause_i) begin
          saved_d = PLAY;
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start_i)      state_d = IDLE;
        else if (pause_i) state_d = saved_q;
      end
      GAMEOVER: begin
        if (start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      saved_q        <= IDLE;
      cnt_q          <= '0;
      tick_q         <= 1'b0;
      cd_q           <= '0;
      scores_q       <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      ball_run_q     <= 1'b0;
      ball_reset_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      saved_q        <= saved_d;
      cnt_q          <= cnt_d;
      tick_q         <= (cnt_d == CNT_W'(FRAME_DIV - 1));
      cd_q           <= cd_d;
      scores_q       <= scores_d;
      winner_q       <= winner_d;
      winner_valid_q <= (state_d == GAMEOVER);
      ball_run_q     <= (state_d == PLAY);
      ball_reset_q   <= (state_d == IDLE) || (state_d == SERVE) ||
                        (state_d == POINT) || (state_d == GAMEOVER);
    end
  end

  assign frame_tick_o   = tick_q;
  assign ball_run_o     = ball_run_q;
  assign ball_reset_o   = ball_reset_q;
  assign scores_o       = scores_q;
  assign winner_o       = winner_q;
  assign winner_valid_o = winner_valid_q;
  assign state_o        = state_q;

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Parametrised game-flow sequencer for the pong family.
- Replaces the ad-hoc start/gamestop toggle with an explicit match FSM: idle, serve countdown, live play, point hold, pause, game over.
- Owns per-player scores for 2-4 players and a frame-rate tick generator.
- Drives the ball's run/reset controls, the score display and win indication.
- Sits between the debounced buttons plus ball/paddle logic and the RGB mux / 7-segment driver.

Parameters:
NUM_PLAYERS, 2, number of players/score channels (2..4)
SCORE_W, 4, width of each score field
WIN_SCORE, 3, score that ends the match (1..2^SCORE_W-1)
FRAME_DIV, 200000, CLK cycles per frame tick
SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released (>=1)
POINT_FRAMES, 90, frame ticks spent in POINT after a score (>=1)
PID_W, 2, width of player index

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse from debouncer (start button)
pause  in  1  one-cycle pulse, pause toggle
point_valid  in  1  one-cycle pulse: a point was scored
point_player  in  PID_W  index of scoring player, sampled with point_valid
frame_tick  out  1  one-cycle pulse every FRAME_DIV cycles
ball_run  out  1  ball may move (state PLAY)
ball_reset  out  1  ball held at centre (IDLE, SERVE, POINT, GAMEOVER)
scores  out  NUM_PLAYERS*SCORE_W  packed scores, player 0 in LSBs
winner  out  PID_W  winning player index, valid with winner_valid
winner_valid  out  1  high in GAMEOVER
state  out  3  state code for the display mux

Behaviour:
- Reset (async, RST=1): state=IDLE (0); scores=0; winner=0; winner_valid=0; ball_run=0; ball_reset=1; tick counter=0; frame_tick=0; countdown=0.
- All outputs are registered and reflect the current state one cycle after the transition edge.
- Tick generator:
  - Counter runs 0..FRAME_DIV-1 and wraps to 0.
  - frame_tick=1 on the cycle where the counter equals FRAME_DIV-1.
  - Free-running in all states, including PAUSE.
- State codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, GAMEOVER=5.
- IDLE:
  - start -> SERVE.
  - On entering SERVE from IDLE, scores clear to 0 and winner_valid=0.
- SERVE:
  - Countdown loads SERVE_FRAMES-1 on entry.
  - On frame_tick: if countdown==0 -> PLAY, else decrement.
  - SERVE therefore lasts exactly SERVE_FRAMES ticks (the partial tick period on entry is not counted).
- PLAY:
  - On point_valid with point_player<NUM_PLAYERS, that score increments by 1.
  - If the new value == WIN_SCORE -> GAMEOVER, winner=point_player.
  - Otherwise -> POINT.
  - point_valid with point_player>=NUM_PLAYERS is ignored; no state change.
- POINT:
  - Countdown loads POINT_FRAMES-1 on entry.
  - Same expiry rule as SERVE; expiry -> SERVE without clearing scores.
- PAUSE:
  - pause in SERVE, PLAY or POINT -> PAUSE; the origin state is saved.
  - In PAUSE, countdown is frozen, frame ticks are ignored and point_valid is ignored.
  - pause -> return to the saved state with the countdown unchanged.
  - ball_run=0 and ball_reset=0 in PAUSE (ball frozen in place).
- GAMEOVER:
  - winner_valid=1 and scores hold.
  - start -> IDLE (scores retained for display until the next start from IDLE).
- Priority in any one cycle: RST > start > point_valid > pause > countdown expiry.
  - start in SERVE, PLAY, POINT or PAUSE aborts to IDLE; scores are kept.
  - point_valid and pause together in PLAY: the point is taken, pause is dropped.
  - pause on the same cycle a countdown expires: pause wins; the saved state is the pre-expiry state and the countdown stays 0, so the transition fires on the first tick after resume.
- Scores never exceed WIN_SCORE; no wrap is possible because GAMEOVER blocks further increments.
- pause in IDLE or GAMEOVER is ignored.

Test Plan:
Parameters for all scenarios: FRAME_DIV=4, SERVE_FRAMES=2, POINT_FRAMES=3, WIN_SCORE=3, NUM_PLAYERS=2.
1. Reset then idle 20 cycles -> state=0, ball_reset=1, ball_run=0, scores=0; frame_tick pulses every 4th cycle starting at cycle 3 after RST drops.
2. start pulse -> state=1; exactly 2 frame_ticks later state=2, ball_run=1.
3. In PLAY, point_valid with player=1 -> scores=8'h10, state=3; 3 ticks later state=1; 2 more ticks later state=2.
4. Player 0 scores 3 times through full serve/point cycles -> state=5, winner=0, winner_valid=1, scores=8'h03; next start -> state=0, scores still 8'h03; next start -> state=1, scores=0.
5. In SERVE with countdown=1, pause -> state=4; 10 ticks pass and state stays 4; pause -> state=1, then 2 ticks -> PLAY.
6. In PLAY, point_valid with player=3 -> ignored, scores unchanged. Same-cycle point_valid(player 0) and pause -> score 0 increments, state=3. RST asserted mid-POINT -> immediate state=0, scores=0.
